riscv_multicycle_controller: RTL
================================

Name: riscv_multicycle_controller

Overview:
- Multicycle control FSM. It sequences one RV32I-subset instruction over 3–5 cycles.
- It is the initiator side of the ALU interface: it drives the 3-bit ALU opcode and consumes the ALU zero flag.
- It sits between the instruction register and the datapath muxes and enables: PC, IR, memory, register file and ALUOut.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag (result == 0)
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR and old-PC load enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1 reg
- alu_src_b  out  2  00 = rs2 reg, 01 = imm, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = data reg, 10 = ALU result, 11 = imm
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_op  out  3  ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLTU 110
- retire  out  1  high in the last cycle of each instruction
- instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_n = 0:
  - state = FETCH and instr_count = 0.
  - pc_write, mem_write, ir_write, reg_write and retire are forced to 0.
- Outputs are combinational from state, opcode, funct3, funct7_5 and zero.
- Defaults in every state: all enables 0, all selects 0, alu_op = ADD, imm_src = I.
- States and outputs (listed values only; everything else takes the default):
  - FETCH: ir_write=1, pc_write=1, a=00, b=10, result_src=10. Next: DECODE.
  - DECODE: a=01, b=01, ADD. imm_src=J if opcode=1101111, else B. Computes the branch/jump target into ALUOut.
  - Next state from DECODE by opcode:
    - 0000011 or 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_TGT
    - 0110111 -> LUI
    - anything else -> illegal handling (see Optional Feature)
  - MEM_ADR: a=10, b=01, ADD, imm_src=S if store else I. Next: MEM_READ (load) or MEM_WRITE (store).
  - MEM_READ: adr_src=1. Next: MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, retire. Next: FETCH.
  - MEM_WRITE: adr_src=1, mem_write=1, retire. Next: FETCH.
  - EXEC_R: a=10, b=00. Next: ALU_WB. alu_op by funct3:
    - 000 -> ADD, or SUB if funct7_5=1
    - 111 -> AND, 110 -> OR, 100 -> XOR
    - 010 -> SLT, 011 -> SLTU
  - EXEC_I: a=10, b=01, imm I. Same mapping as EXEC_R but funct7_5 is ignored, so 000 -> ADD. Next: ALU_WB.
  - Unsupported funct3 in EXEC_R/EXEC_I (001, 101) is illegal. This is detected in DECODE.
  - ALU_WB: result_src=00, reg_write=1, retire. Next: FETCH.
  - BRANCH: a=10, b=00, result_src=00, retire. Next: FETCH.
    - beq (000): SUB, pc_write=zero.
    - bne (001): SUB, pc_write=~zero.
    - blt (100): SLT, pc_write=~zero.
    - bge (101): SLT, pc_write=zero.
    - Any other funct3: not taken, pc_write=0.
  - JAL: a=01, b=10, ADD, result_src=00, pc_write=1. PC <= target; ALUOut <= oldPC+4. Next: ALU_WB.
  - JALR_TGT: a=10, b=01, imm I, ADD. Next: JALR_LINK.
  - JALR_LINK: identical to JAL. Next: ALU_WB.
  - LUI: imm_src=U, result_src=11, reg_write=1, retire. Next: FETCH.
- instr_count increments by 1 on each clock edge where retire=1 and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: the state returns to FETCH immediately. No partial write may occur after rst_n falls.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined:
  - An illegal opcode or unsupported funct3 moves the FSM from DECODE to HALT.
  - In HALT all enables are 0, there is no retire, and the FSM stays there until reset.
  - An extra output port illegal (1 bit) is high while in HALT.
- When undefined:
  - Illegal instructions are treated as a NOP: DECODE -> FETCH with retire=1 in DECODE.
  - The illegal port does not exist.

Test Plan:
1. Reset, then release, with opcode=0110011, funct3=000, funct7_5=1 -> states FETCH, DECODE, EXEC_R (alu_op=001), ALU_WB (reg_write=1); instr_count=1 after 4 cycles.
2. lw (0000011) -> 5 cycles; MEM_READ adr_src=1; MEM_WB result_src=01, reg_write=1. sw (0100011) -> 4 cycles; mem_write=1 only in MEM_WRITE; imm_src=001 in MEM_ADR.
3. Branch checks, 3 cycles each:
   - beq with zero=1 -> pc_write=1; with zero=0 -> pc_write=0.
   - blt -> alu_op=101; zero=0 -> pc_write=1.
   - bge with zero=0 -> pc_write=0.
4. jal -> DECODE imm_src=011; JAL pc_write=1; ALU_WB reg_write=1; 4 cycles. jalr -> 5 cycles; JALR_TGT a=10, b=01.
5. opcode=1111111:
   - With ILLEGAL_TRAP_EN: HALT, illegal=1, all enables stay 0 for 10 cycles.
   - Without it: back to FETCH after 2 cycles, instr_count increments.
6. rst_n pulsed low during MEM_WRITE -> mem_write drops asynchronously, state=FETCH, instr_count=0.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// rtl/riscv_multicycle_controller.sv - multicycle RV32I-subset control FSM
// Optional macro ILLEGAL_TRAP_EN: illegal instructions halt the FSM and raise the illegal port.
module riscv_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic [2:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR_TGT  = 4'd11;
  localparam logic [3:0] S_JALR_LINK = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT      = 4'd14;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0] state, state_nxt;
  logic [2:0] alu_dec;
  logic       is_illegal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, retire_c;

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    is_illegal = 1'b1;
    case (opcode)
      OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI: is_illegal = 1'b0;
      OP_R, OP_I: is_illegal = (funct3 == 3'b001) || (funct3 == 3'b101);
      default:    is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt   = S_FETCH;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = IMM_I;
    alu_op      = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
            OP_R:              state_nxt = S_EXEC_R;
            OP_I:              state_nxt = S_EXEC_I;
            OP_BR:             state_nxt = S_BRANCH;
            OP_JAL:            state_nxt = S_JAL;
            OP_JALR:           state_nxt = S_JALR_TGT;
            default:           state_nxt = S_LUI;
          endcase
        end
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src   = 1'b1;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : alu_dec;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_dec;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      // blt/bge use SLT, so a set result (zero = 0) means "less than".
      S_BRANCH: begin
        alu_src_a = 2'b10;
        retire_c  = 1'b1;
        case (funct3)
          3'b000: begin alu_op = ALU_SUB; pc_write_c = zero;  end
          3'b001: begin alu_op = ALU_SUB; pc_write_c = ~zero; end
          3'b100: begin alu_op = ALU_SLT; pc_write_c = ~zero; end
          3'b101: begin alu_op = ALU_SLT; pc_write_c = zero;  end
          default: pc_write_c = 1'b0;
        endcase
      end
      S_JAL, S_JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_nxt  = S_ALU_WB;
      end
      S_JALR_TGT: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = S_JALR_LINK;
      end
      S_LUI: begin
        imm_src     = IMM_U;
        result_src  = 2'b11;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Gate enables with rst_n so nothing writes once reset falls, even mid-cycle.
  assign pc_write  = pc_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign retire    = retire_c    & rst_n;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_HALT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instr_count <= '0;
    else if (retire_c) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
